channel_selector: RTL and testbench
===================================

CHANNEL_SELECTOR -- requirements
Module: channel_selector

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waited for any single CU tag response.
REQ-002 SHALL have parameter SETUP, default 2: cycles bus_out must be stable before a tag is raised.
REQ-003 SHALL have ports, in this order:
- aclk  in  1  clock
- aresetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that starts an initial selection
- dev_addr  in  8  device address
- cmd  in  8  command byte
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- result  out  2  result code: 0 ok, 1 no device, 2 timeout, 3 address mismatch
- dev_status  out  8  status byte captured from the CU
- bus_out  out  8  channel bus out
- operational_out, hold_out, select_out, address_out, command_out, service_out, suppress_out  out  1 each  channel out-tags
- bus_in  in  8  channel bus in
- operational_in, address_in, status_in, select_in, request_in, service_in  in  1 each  CU in-tags

Function
REQ-004 SHALL register all outputs; no combinational path from any input to any output.
REQ-005 SHALL hold operational_out=1 whenever not in reset; suppress_out SHALL be constant 0.
REQ-006 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored, with no queueing.
REQ-007 SHALL latch dev_addr and cmd on an accepted start and set busy=1 on the next cycle.
REQ-008 SHALL implement states IDLE, ADDR_SETUP, ADDR_WAIT, CMD_WAIT, STATUS_WAIT, STATUS_ACK, RELEASE, DONE.
REQ-009 ADDR_SETUP: bus_out=addr, address_out=1; after SETUP cycles, hold_out=select_out=1 and go to ADDR_WAIT.
REQ-010 ADDR_WAIT transitions:
- select_in=1: result=1, go to RELEASE.
- operational_in=1 and address_in=1: if bus_in==addr, drop address_out, drive bus_out=cmd and command_out=1, go to CMD_WAIT; otherwise result=3, go to RELEASE.
REQ-011 In ADDR_WAIT, if select_in and address_in rise in the same cycle, select_in SHALL take priority (result=1).
REQ-012 CMD_WAIT: when address_in=0, SHALL drop command_out, set bus_out=0, and go to STATUS_WAIT.
REQ-013 STATUS_WAIT: when status_in=1, SHALL capture bus_in into dev_status, set service_out=1, and go to STATUS_ACK.
REQ-014 STATUS_ACK: when status_in=0, SHALL drop service_out, set result=0, and go to RELEASE.
REQ-015 RELEASE: SHALL drop hold_out, select_out, address_out, command_out, service_out and set bus_out=0; in the following cycle (DONE) SHALL pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-016 SHALL keep one 8-bit wait counter, cleared on every state entry and saturating at TIMEOUT.
REQ-017 In ADDR_WAIT, CMD_WAIT, STATUS_WAIT or STATUS_ACK, a counter reaching TIMEOUT SHALL set result=2 and go to RELEASE; the timeout is taken on the cycle the count equals TIMEOUT, not after wrap.
REQ-018 SHALL hold result and dev_status stable from done until the next accepted start; dev_status SHALL be 0 for results 1-3.
REQ-019 SHALL ignore request_in and service_in; they are reserved for a later data-transfer phase.
REQ-020 Exactly one of address_out, command_out, service_out SHALL be high in any cycle, or none.

Reset
REQ-021 On aresetn=0 at a clock edge, SHALL force IDLE from any state, mid-sequence included, with no done pulse.
REQ-022 Reset values: busy=0, done=0, result=0, dev_status=0, bus_out=0, all out-tags 0 (operational_out=0 during reset, 1 on the first cycle after).
REQ-023 The counter and the latched addr/cmd SHALL reset to 0.

Verification
REQ-024 Normal: addr=0x50, cmd=0x02; CU echoes 0x50 with address_in, then returns status 0x0C -> dev_status=0x0C, result=0, done pulse, all tags low after done.
REQ-025 No device: CU returns select_in=1 in ADDR_WAIT -> result=1, hold_out/select_out low by RELEASE, dev_status=0.
REQ-026 Mismatch: addr=0x50, CU echoes 0x51 -> result=3, command_out never asserted.
REQ-027 Timeout: CU never answers in STATUS_WAIT -> result=2 after exactly 255 waiting cycles; service_out never asserted.
REQ-028 Reset mid-sequence: aresetn=0 for 1 cycle during CMD_WAIT -> next cycle all tags 0, busy=0, done never pulses; a following start completes normally.
REQ-029 Busy start: start pulsed during STATUS_WAIT with a new addr -> ignored; the running sequence completes with the original addr/cmd.

Source files
------------

// File: rtl/channel_selector.sv
// Channel-side initial selection sequencer: address a CU, issue one command,
// collect its status byte and release the channel.
module channel_selector #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned SETUP   = 2
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       start,
  input  logic [7:0] dev_addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [7:0] dev_status,
  output logic [7:0] bus_out,
  output logic       operational_out,
  output logic       hold_out,
  output logic       select_out,
  output logic       address_out,
  output logic       command_out,
  output logic       service_out,
  output logic       suppress_out,
  input  logic [7:0] bus_in,
  input  logic       operational_in,
  input  logic       address_in,
  input  logic       status_in,
  input  logic       select_in,
  input  logic       request_in,
  input  logic       service_in
);

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_WAIT, CMD_WAIT, STATUS_WAIT, STATUS_ACK, RELEASE, DONE
  } state_t;

  localparam logic [7:0] TO_MAX     = 8'(TIMEOUT);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);

  localparam logic [1:0] RES_OK      = 2'd0;
  localparam logic [1:0] RES_NODEV   = 2'd1;
  localparam logic [1:0] RES_TIMEOUT = 2'd2;
  localparam logic [1:0] RES_MISM    = 2'd3;

  state_t     state, nxt_state;
  logic [7:0] cnt;
  logic [7:0] addr_q, cmd_q, nxt_addr_q, nxt_cmd_q;
  logic       nxt_busy, nxt_done;
  logic [1:0] nxt_result;
  logic [7:0] nxt_dev_status, nxt_bus_out;
  logic       nxt_hold, nxt_select, nxt_address, nxt_command, nxt_service;
  logic       timed_out;

  // Reserved for the data-transfer phase.
  logic unused_tags;
  assign unused_tags = request_in ^ service_in;

  assign timed_out    = (cnt == TO_MAX);
  assign suppress_out = 1'b0;

  always_comb begin
    nxt_state      = state;
    nxt_addr_q     = addr_q;
    nxt_cmd_q      = cmd_q;
    nxt_busy       = busy;
    nxt_done       = 1'b0;
    nxt_result     = result;
    nxt_dev_status = dev_status;
    nxt_bus_out    = bus_out;
    nxt_hold       = hold_out;
    nxt_select     = select_out;
    nxt_address    = address_out;
    nxt_command    = command_out;
    nxt_service    = service_out;

    case (state)
      IDLE: begin
        if (start) begin
          nxt_addr_q     = dev_addr;
          nxt_cmd_q      = cmd;
          nxt_busy       = 1'b1;
          nxt_result     = RES_OK;
          nxt_dev_status = '0;
          nxt_bus_out    = dev_addr;
          nxt_address    = 1'b1;
          nxt_state      = ADDR_SETUP;
        end
      end
      ADDR_SETUP: begin
        if (cnt == SETUP_LAST) begin
          nxt_hold   = 1'b1;
          nxt_select = 1'b1;
          nxt_state  = ADDR_WAIT;
        end
      end
      ADDR_WAIT: begin
        if (select_in) begin
          nxt_result = RES_NODEV;
          nxt_state  = RELEASE;
        end else if (operational_in && address_in) begin
          if (bus_in == addr_q) begin
            nxt_address = 1'b0;
            nxt_bus_out = cmd_q;
            nxt_command = 1'b1;
            nxt_state   = CMD_WAIT;
          end else begin
            nxt_result = RES_MISM;
            nxt_state  = RELEASE;
          end
        end else if (timed_out) begin
          nxt_result = RES_TIMEOUT;
          nxt_state  = RELEASE;
        end
      end
      CMD_WAIT: begin
        if (!address_in) begin
          nxt_command = 1'b0;
          nxt_bus_out = '0;
          nxt_state   = STATUS_WAIT;
        end else if (timed_out) begin
          nxt_result = RES_TIMEOUT;
          nxt_state  = RELEASE;
        end
      end
      STATUS_WAIT: begin
        if (status_in) begin
          nxt_dev_status = bus_in;
          nxt_service    = 1'b1;
          nxt_state      = STATUS_ACK;
        end else if (timed_out) begin
          nxt_result = RES_TIMEOUT;
          nxt_state  = RELEASE;
        end
      end
      STATUS_ACK: begin
        if (!status_in) begin
          nxt_service = 1'b0;
          nxt_result  = RES_OK;
          nxt_state   = RELEASE;
        end else if (timed_out) begin
          nxt_result = RES_TIMEOUT;
          nxt_state  = RELEASE;
        end
      end
      RELEASE: begin
        nxt_done  = 1'b1;
        nxt_busy  = 1'b0;
        nxt_state = DONE;
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    // Every path into RELEASE shares the same tag drop; failures also void the status byte.
    if (nxt_state == RELEASE) begin
      nxt_hold    = 1'b0;
      nxt_select  = 1'b0;
      nxt_address = 1'b0;
      nxt_command = 1'b0;
      nxt_service = 1'b0;
      nxt_bus_out = '0;
      if (nxt_result != RES_OK) nxt_dev_status = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= IDLE;
      addr_q          <= '0;
      cmd_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= '0;
      dev_status      <= '0;
      bus_out         <= '0;
      operational_out <= 1'b0;
      hold_out        <= 1'b0;
      select_out      <= 1'b0;
      address_out     <= 1'b0;
      command_out     <= 1'b0;
      service_out     <= 1'b0;
    end else begin
      state           <= nxt_state;
      addr_q          <= nxt_addr_q;
      cmd_q           <= nxt_cmd_q;
      busy            <= nxt_busy;
      done            <= nxt_done;
      result          <= nxt_result;
      dev_status      <= nxt_dev_status;
      bus_out         <= nxt_bus_out;
      operational_out <= 1'b1;
      hold_out        <= nxt_hold;
      select_out      <= nxt_select;
      address_out     <= nxt_address;
      command_out     <= nxt_command;
      service_out     <= nxt_service;
    end
  end

  // Cleared on every state entry, parks at TIMEOUT instead of wrapping.
  always_ff @(posedge aclk) begin
    if (!aresetn)                cnt <= '0;
    else if (nxt_state != state) cnt <= '0;
    else if (cnt != TO_MAX)      cnt <= cnt + 8'd1;
  end

endmodule

// File: tb/tb_channel_selector.sv
// Randomized bench for channel_selector: the bench plays the CU and predicts
// each outcome from the selection rules.
module tb_channel_selector;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned SETUP   = 2;

  localparam int K_OK = 0, K_NODEV = 1, K_MISM = 2, K_TO = 3, K_BOTH = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dev_addr = '0, cmd = '0;
  logic       busy, done;
  logic [1:0] result;
  logic [7:0] dev_status, bus_out;
  logic       operational_out, hold_out, select_out, address_out, command_out, service_out, suppress_out;
  logic [7:0] bus_in = '0;
  logic       operational_in = 1'b0, address_in = 1'b0, status_in = 1'b0, select_in = 1'b0;
  logic       request_in = 1'b0, service_in = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Written only by the monitor.
  int  onehot_err = 0, dwidth_err = 0, supp_err = 0;
  int  cmd_cnt = 0, svc_cnt = 0, done_cnt = 0;
  logic prev_done = 1'b0;

  channel_selector #(.TIMEOUT(TIMEOUT), .SETUP(SETUP)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .dev_addr(dev_addr), .cmd(cmd),
    .busy(busy), .done(done), .result(result), .dev_status(dev_status), .bus_out(bus_out),
    .operational_out(operational_out), .hold_out(hold_out), .select_out(select_out),
    .address_out(address_out), .command_out(command_out), .service_out(service_out),
    .suppress_out(suppress_out), .bus_in(bus_in), .operational_in(operational_in),
    .address_in(address_in), .status_in(status_in), .select_in(select_in),
    .request_in(request_in), .service_in(service_in)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (32'($countones({address_out, command_out, service_out})) > 1) onehot_err++;
    if (done && prev_done) dwidth_err++;
    if (suppress_out !== 1'b0) supp_err++;
    if (command_out) cmd_cnt++;
    if (service_out) svc_cnt++;
    if (done) done_cnt++;
    prev_done = done;
  end

  task automatic release_cu();
    operational_in = 1'b0; address_in = 1'b0; status_in = 1'b0; select_in = 1'b0; bus_in = '0;
  endtask

  task automatic wait_for(input string tag, input int which, input int limit);
    int n;
    logic s;
    n = 0;
    s = 1'b0;
    while (n < limit) begin
      case (which)
        0: s = select_out;
        1: s = command_out;
        2: s = service_out;
        default: s = done;
      endcase
      if (s) break;
      @(negedge aclk);
      n++;
    end
    check(tag, 32'(s), 32'd1);
  endtask

  task automatic run_txn(input int kind, input logic [7:0] a, input logic [7:0] c,
                         input logic [7:0] st, input bit busy_start);
    logic [7:0] echo;
    bit         sel, answered;
    logic [1:0] exp_res;
    logic [7:0] exp_st;
    int         n, cmd0, svc0;

    sel      = (kind == K_NODEV) || (kind == K_BOTH);
    echo     = (kind == K_MISM) ? (a ^ 8'($urandom_range(1, 255))) : a;
    answered = (kind == K_OK);
    cmd0     = cmd_cnt;
    svc0     = svc_cnt;

    @(negedge aclk);
    start = 1'b1; dev_addr = a; cmd = c;
    @(negedge aclk);
    start = 1'b0; dev_addr = 8'($urandom); cmd = 8'($urandom);
    check("busy_set", 32'(busy), 32'd1);
    check("addr_tag", 32'(address_out), 32'd1);
    check("addr_bus", 32'(bus_out), 32'(a));

    wait_for("select_rise", 0, 20);
    check("hold_rise", 32'(hold_out), 32'd1);
    check("addr_bus_held", 32'(bus_out), 32'(a));
    repeat ($urandom_range(0, 4)) @(negedge aclk);

    if (sel) select_in = 1'b1;
    if (kind != K_NODEV) begin
      operational_in = 1'b1; address_in = 1'b1; bus_in = echo;
    end

    if (kind == K_OK || kind == K_TO) begin
      wait_for("cmd_rise", 1, 20);
      check("cmd_bus", 32'(bus_out), 32'(c));
      check("addr_drop", 32'(address_out), 32'd0);
      repeat ($urandom_range(0, 4)) @(negedge aclk);
      address_in = 1'b0;
      @(negedge aclk);
      check("cmd_fall", 32'(command_out), 32'd0);
      check("bus_zero", 32'(bus_out), 32'd0);
      if (kind == K_TO) begin
        n = 0;
        while (!done && n < 1000) begin
          @(negedge aclk);
          n++;
        end
        check("to_latency", 32'(n), 32'(TIMEOUT + 2));
      end else begin
        if (busy_start) begin
          start = 1'b1; dev_addr = ~a; cmd = ~c;
          @(negedge aclk);
          start = 1'b0;
        end
        repeat ($urandom_range(0, 4)) @(negedge aclk);
        status_in = 1'b1; bus_in = st;
        wait_for("svc_rise", 2, 20);
        repeat ($urandom_range(0, 4)) @(negedge aclk);
        status_in = 1'b0; bus_in = 8'($urandom);
      end
    end

    wait_for("done_seen", 3, 1000);

    // Reference outcome straight from the selection rules.
    if (sel)            exp_res = 2'd1;
    else if (echo != a) exp_res = 2'd3;
    else if (answered)  exp_res = 2'd0;
    else                exp_res = 2'd2;
    exp_st = (exp_res == 2'd0) ? st : 8'h00;

    check("result", 32'(result), 32'(exp_res));
    check("dev_status", 32'(dev_status), 32'(exp_st));
    check("busy_clear", 32'(busy), 32'd0);
    check("tags_low", 32'({hold_out, select_out, address_out, command_out, service_out}), 32'd0);
    check("bus_low", 32'(bus_out), 32'd0);
    check("cmd_seen", 32'(cmd_cnt != cmd0), 32'(kind == K_OK || kind == K_TO));
    check("svc_seen", 32'(svc_cnt != svc0), 32'(answered));
    release_cu();

    repeat (3) @(negedge aclk);
    check("done_once", 32'(done), 32'd0);
    check("idle_after", 32'({busy, address_out}), 32'd0);
    check("result_hold", 32'(result), 32'(exp_res));
    check("status_hold", 32'(dev_status), 32'(exp_st));
  endtask

  initial begin
    int d0, kind;

    repeat (3) @(negedge aclk);
    check("rst_outputs", 32'({busy, done, result, dev_status, bus_out}), 32'd0);
    check("rst_tags", 32'({operational_out, hold_out, select_out, address_out, command_out, service_out}), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("oper_after_rst", 32'(operational_out), 32'd1);

    // Directed cases from the selection scenarios.
    run_txn(K_OK,   8'h50, 8'h02, 8'h0C, 1'b0);
    run_txn(K_NODEV,8'h50, 8'h02, 8'h0C, 1'b0);
    run_txn(K_MISM, 8'h50, 8'h02, 8'h0C, 1'b0);
    run_txn(K_TO,   8'h50, 8'h02, 8'h0C, 1'b0);
    run_txn(K_BOTH, 8'h50, 8'h02, 8'h0C, 1'b0);
    run_txn(K_OK,   8'h33, 8'h44, 8'hA5, 1'b1);

    // Reset during CMD_WAIT.
    d0 = done_cnt;
    @(negedge aclk);
    start = 1'b1; dev_addr = 8'h21; cmd = 8'h07;
    @(negedge aclk);
    start = 1'b0;
    wait_for("rst_sel", 0, 20);
    operational_in = 1'b1; address_in = 1'b1; bus_in = 8'h21;
    wait_for("rst_cmd", 1, 20);
    aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_tags", 32'({operational_out, hold_out, select_out, address_out, command_out, service_out}), 32'd0);
    check("midrst_state", 32'({busy, done, bus_out}), 32'd0);
    aresetn = 1'b1;
    release_cu();
    repeat (4) @(negedge aclk);
    check("midrst_oper", 32'(operational_out), 32'd1);
    check("midrst_nodone", 32'(done_cnt), 32'(d0));
    run_txn(K_OK, 8'h21, 8'h07, 8'h3C, 1'b0);

    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 4);
      run_txn(kind, 8'($urandom), 8'($urandom), 8'($urandom), (kind == K_OK) && ($urandom_range(0, 1) == 1));
    end

    check("onehot_violations", 32'(onehot_err), 32'd0);
    check("done_width_violations", 32'(dwidth_err), 32'd0);
    check("suppress_violations", 32'(supp_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
